// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: captures one byte per rxDone rising edge, first-word-fall-through read side.
// Define UART_RX_FIFO_DROP_ERR_EN to discard framing-errored bytes instead of storing them with an error tag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rxDone,
  input  logic          rxErr,
  input  logic [7:0]    rxByte,
  output logic          outValid,
  input  logic          outReady,
  output logic [7:0]    outByte,
  output logic          outErr,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          ovfClear
);

`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam int EW = 8;
`else
  localparam int EW = 9;
`endif

  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  logic [EW-1:0] mem [0:DEPTH-1];
  logic [EW-1:0] entryIn;
  logic [EW-1:0] headEntry;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          rxDonePrev;
  logic          rxRise;
  logic          wrReq;
  logic          pop;
  logic          doWrite;
  logic          ovfEvent;

  assign rxRise = rxDone && !rxDonePrev;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign wrReq   = rxRise && !rxErr;
  assign entryIn = rxByte;
`else
  assign wrReq   = rxRise;
  assign entryIn = {rxErr, rxByte};
`endif

  assign full     = (level == FullLevel);
  assign empty    = (level == '0);
  assign outValid = !empty;
  assign pop      = outValid && outReady;
  // A full FIFO still takes a byte when the consumer frees a slot in the same cycle.
  assign doWrite  = wrReq && (!full || pop);
  assign ovfEvent = wrReq && full && !pop;

  assign headEntry = mem[head];
  assign outByte   = headEntry[7:0];
`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign outErr = 1'b0;
`else
  assign outErr = headEntry[8];
`endif

  // Storage is not reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[tail] <= entryIn;
    end
  end

  // rxDonePrev resets high so a level already asserted at reset release is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      rxDonePrev <= 1'b1;
    end else begin
      rxDonePrev <= rxDone;
      if (doWrite) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({doWrite, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (ovfEvent) begin
        overflow <= 1'b1;
      end else if (ovfClear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16); outputs are sampled 1ns after each rising clk edge.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxDone = 1'b0;
  logic       rxErr = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic       outValid;
  logic       outReady = 1'b0;
  logic [7:0] outByte;
  logic       outErr;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovfClear = 1'b0;

  int total = 0;
  int bad = 0;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .outValid(outValid), .outReady(outReady), .outByte(outByte), .outErr(outErr),
    .level(level), .full(full), .empty(empty), .overflow(overflow), .ovfClear(ovfClear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one rxDone pulse (high one cycle, low one cycle) carrying the given byte.
  task automatic applyStimulus(input logic [7:0] b, input logic e);
    rxDone = 1'b1;
    rxByte = b;
    rxErr  = e;
    tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
    tick();
  endtask

  initial begin
    int rdIdx;
    int maxLevel;

    // Reset state
    #2;
    checkOutput("rstValid", outValid, 0);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstFull", full, 0);
    checkOutput("rstOverflow", overflow, 0);
    checkOutput("rstLevel", level, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single byte with rxDone held five cycles
    rxDone = 1'b1; rxByte = 8'hB5; rxErr = 1'b0;
    #1;
    checkOutput("noBypass", outValid, 0);
    tick();
    checkOutput("singleValid", outValid, 1);
    checkOutput("singleByte", outByte, 8'hB5);
    checkOutput("singleErr", outErr, 0);
    checkOutput("singleLevel", level, 1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("heldLevel", level, 1);
    rxDone = 1'b0; outReady = 1'b1;
    tick();
    checkOutput("singlePopEmpty", empty, 1);
    tick();
    checkOutput("popWhenEmptyLevel", level, 0);
    outReady = 1'b0;

    // Fill and overflow
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("fillFull", full, 1);
    checkOutput("fillLevel", level, 16);
    checkOutput("fillNoOvf", overflow, 0);
    applyStimulus(8'h10, 1'b0);
    checkOutput("ovfSet", overflow, 1);
    checkOutput("ovfLevel", level, 16);
    ovfClear = 1'b1;
    tick();
    ovfClear = 1'b0;
    checkOutput("ovfCleared", overflow, 0);
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("drainByte", outByte, i);
      tick();
    end
    checkOutput("drainEmpty", empty, 1);
    outReady = 1'b0;

    // Full with simultaneous write and pop
    for (int i = 0; i < 16; i++) applyStimulus(8'h40 + 8'(i), 1'b0);
    tick(); tick();
    checkOutput("stableByte", outByte, 8'h40);
    rxDone = 1'b1; rxByte = 8'hAA; outReady = 1'b1;
    tick();
    rxDone = 1'b0;
    checkOutput("simLevel", level, 16);
    checkOutput("simNoOvf", overflow, 0);
    for (int i = 1; i < 16; i++) begin
      checkOutput("simDrain", outByte, 8'h40 + 8'(i));
      tick();
    end
    checkOutput("simLast", outByte, 8'hAA);
    tick();
    checkOutput("simEmpty", empty, 1);
    outReady = 1'b0;

    // Error tag
    applyStimulus(8'h3C, 1'b1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    checkOutput("errDropLevel", level, 0);
    checkOutput("errDropValid", outValid, 0);
`else
    checkOutput("errValid", outValid, 1);
    checkOutput("errTag", outErr, 1);
    checkOutput("errByte", outByte, 8'h3C);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("errPopped", empty, 1);
`endif

    // rxDone held through reset release is not captured
    rxDone = 1'b1; rxByte = 8'h77;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checkOutput("heldAtRelease", level, 0);
    rxDone = 1'b0;
    tick();

    // Overflow set wins over a same-cycle clear
    for (int i = 0; i < 16; i++) applyStimulus(8'h60 + 8'(i), 1'b0);
    rxDone = 1'b1; rxByte = 8'hEE; ovfClear = 1'b1;
    tick();
    rxDone = 1'b0;
    checkOutput("setWins", overflow, 1);
    tick();
    ovfClear = 1'b0;
    checkOutput("clearNext", overflow, 0);

    // Reset mid-operation discards entries
    rst_n = 1'b0;
    #1;
    checkOutput("midRstEmpty", empty, 1);
    checkOutput("midRstLevel", level, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Wrap-around stream
    rdIdx = 0;
    maxLevel = 0;
    outReady = 1'b1;
    for (int i = 0; i < 42; i++) begin
      if (i < 40) begin
        rxDone = 1'b1; rxByte = 8'h80 + 8'(i);
      end
      tick();
      if (outValid) begin
        checkOutput("wrapByte", outByte, 8'h80 + 8'(rdIdx));
        rdIdx++;
      end
      if (int'(level) > maxLevel) maxLevel = int'(level);
      rxDone = 1'b0;
      tick();
      if (outValid) begin
        checkOutput("wrapByte", outByte, 8'h80 + 8'(rdIdx));
        rdIdx++;
      end
      if (int'(level) > maxLevel) maxLevel = int'(level);
    end
    checkOutput("wrapCount", rdIdx, 40);
    checkOutput("wrapMaxLevelOk", (maxLevel <= 2), 1);
    checkOutput("wrapEmpty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; must be a power of 2 and at least 2.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rxDone, input, 1, receiver byte-complete level from the UART receiver.
REQ-006 SHALL have port rxErr, input, 1, receiver framing error, qualified by rxDone.
REQ-007 SHALL have port rxByte, input, 8, received byte, qualified by rxDone.
REQ-008 SHALL have port outValid, output, 1, head entry available.
REQ-009 SHALL have port outReady, input, 1, consumer accepts head.
REQ-010 SHALL have port outByte, output, 8, head byte.
REQ-011 SHALL have port outErr, output, 1, head error tag.
REQ-012 SHALL have port level, output, AW+1, current entry count.
REQ-013 SHALL have ports full and empty, output, 1 each, occupancy flags.
REQ-014 SHALL have port overflow, output, 1, sticky dropped-byte flag.
REQ-015 SHALL have port ovfClear, input, 1, clears overflow.

Function
REQ-016 SHALL create a write request on the rising edge of rxDone (rxDone=1 and registered rxDonePrev=0), so that a multi-cycle rxDone level yields exactly one write.
REQ-017 SHALL store {rxErr, rxByte} sampled in the request cycle at the tail, then increment the tail pointer modulo DEPTH.
REQ-018 SHALL be first-word-fall-through: outByte/outErr come combinationally from the head entry, and outValid = !empty.
REQ-019 SHALL pop when outValid && outReady, incrementing the head pointer modulo DEPTH.
REQ-020 SHALL hold latency at one cycle: a write request at edge N gives outValid=1 after edge N when the FIFO was empty.
REQ-021 SHALL keep outByte/outErr stable while outValid=1 and outReady=0.
REQ-022 SHALL update level: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-023 SHALL drive full = (level==DEPTH) and empty = (level==0).
REQ-024 SHALL accept a write when full only if a pop occurs in the same cycle; level stays DEPTH.
REQ-025 SHALL, on a write when full with no pop, drop the byte, set overflow, and leave pointers and level unchanged.
REQ-026 SHALL, on a write request while empty, not bypass the byte to the output in the same cycle.
REQ-027 SHALL clear overflow on ovfClear=1; if an overflow event occurs in the same cycle, set wins.
REQ-028 SHALL ignore a pop when empty.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously reset head, tail, level, and overflow to 0, and rxDonePrev to 1.
REQ-030 SHALL therefore drive outValid=0, empty=1, full=0, and overflow=0 during reset.
REQ-031 SHALL not write an rxDone level that is high at reset release; only a later rising edge is captured.
REQ-032 SHALL, on reset mid-operation, discard all stored entries; storage contents need not be cleared.

Configuration
REQ-033 SHALL, with UART_RX_FIFO_DROP_ERR_EN defined, discard write requests with rxErr=1 (no store, no pointer or level change, overflow unaffected); outErr is then tied to 0.
REQ-034 SHALL, without UART_RX_FIFO_DROP_ERR_EN, store errored bytes and present rxErr as outErr.

Verification
REQ-035 SHALL cover single byte: rxDone rises with rxByte=0xB5, rxErr=0, held 5 cycles -> one entry; outValid=1 next cycle, outByte=0xB5, level=1; pop -> empty=1.
REQ-036 SHALL cover fill and overflow: 17 rxDone pulses 0x00..0x10 with outReady=0 -> full=1 after the 16th; the 17th sets overflow=1 and level=16; reads return 0x00..0x0F in order.
REQ-037 SHALL cover full with simultaneous write and pop: with DEPTH entries, write 0xAA and pop in the same cycle -> overflow stays 0, level=16, 0xAA returned last.
REQ-038 SHALL cover error tag: rxByte=0x3C with rxErr=1 -> without macro, outErr=1 and outByte=0x3C; with macro, level stays 0 and outValid=0.
REQ-039 SHALL cover reset and clear: rxDone=1 held through rst_n release -> no write; a later overflow event with ovfClear=1 in the same cycle -> overflow=1; ovfClear next cycle -> overflow=0.
REQ-040 SHALL cover wrap-around: 40 bytes streamed with outReady=1 -> bytes returned in order, level never exceeds 2, pointers wrap with no loss.
